// File: rtl/l1_dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Fills and evicts 4-word lines through a request/ready handshake with the lower level.
module l1_dcache_ctrl #(
  parameter int unsigned INDEX_W = 3,
  parameter int unsigned TAG_W   = 25
) (
  input  logic          clk,
  input  logic          proc_reset,
  input  logic          proc_read,
  input  logic          proc_write,
  input  logic [29:0]   proc_addr,
  input  logic [31:0]   proc_wdata,
  output logic          proc_stall,
  output logic [31:0]   proc_rdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic [27:0]   mem_addr,
  output logic [127:0]  mem_wdata,
  input  logic [127:0]  mem_rdata,
  input  logic          mem_ready
);

  localparam int unsigned Lines = 1 << INDEX_W;

  typedef enum logic [1:0] {StCompare, StWriteback, StAllocate} state_e;

  state_e state_q, state_d;

  logic [Lines-1:0] valid_q, valid_d;
  logic [Lines-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0] tag_q  [Lines];
  logic [127:0]     data_q [Lines];

  logic         mem_read_q, mem_read_d;
  logic         mem_write_q, mem_write_d;
  logic [27:0]  mem_addr_q, mem_addr_d;
  logic [127:0] mem_wdata_q, mem_wdata_d;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   ptag;
  logic [1:0]         woff;
  logic               req;
  logic               hit;

  logic               line_we;
  logic [127:0]       line_d;
  logic [TAG_W-1:0]   tag_d;

  assign idx  = proc_addr[1+INDEX_W:2];
  assign ptag = proc_addr[29:2+INDEX_W];
  assign woff = proc_addr[1:0];
  assign req  = proc_read | proc_write;
  assign hit  = valid_q[idx] && (tag_q[idx] == ptag);

  // State register
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q     <= StCompare;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Tag and data arrays need no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (line_we) begin
      data_q[idx] <= line_d;
      tag_q[idx]  <= tag_d;
    end
  end

  // Next state and registered lower-level request
  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      StCompare: begin
        if (req && !hit) begin
          if (valid_q[idx] && dirty_q[idx]) begin
            state_d     = StWriteback;
            mem_write_d = 1'b1;
            mem_addr_d  = {tag_q[idx], idx};
            mem_wdata_d = data_q[idx];
          end else begin
            state_d    = StAllocate;
            mem_read_d = 1'b1;
            mem_addr_d = {ptag, idx};
          end
        end
      end
      StWriteback: begin
        if (mem_ready) begin
          state_d     = StAllocate;
          mem_write_d = 1'b0;
          mem_read_d  = 1'b1;
          mem_addr_d  = {ptag, idx};
        end
      end
      StAllocate: begin
        if (mem_ready) begin
          state_d    = StCompare;
          mem_read_d = 1'b0;
        end
      end
      default: state_d = StCompare;
    endcase
  end

  // Array update: fill on completion, or store merge on a compare hit
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    line_we = 1'b0;
    line_d  = data_q[idx];
    tag_d   = tag_q[idx];
    if (state_q == StAllocate && mem_ready) begin
      line_we      = 1'b1;
      line_d       = mem_rdata;
      tag_d        = ptag;
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
    end else if (state_q == StCompare && proc_write && hit) begin
      line_we                   = 1'b1;
      line_d[{woff, 5'b0} +: 32] = proc_wdata;
      dirty_d[idx]              = 1'b1;
    end
  end

  // Outputs
  always_comb begin
    proc_stall = (state_q == StCompare) ? (req && !hit) : 1'b1;
    proc_rdata = data_q[idx][{woff, 5'b0} +: 32];
    mem_read   = mem_read_q;
    mem_write  = mem_write_q;
    mem_addr   = mem_addr_q;
    mem_wdata  = mem_wdata_q;
  end

endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// Randomized self-checking bench for l1_dcache_ctrl against a line-level cache
// model plus a backing-store memory model.
module tb_l1_dcache_ctrl;

  logic         clk = 1'b0;
  logic         proc_reset;
  logic         proc_read, proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model
  bit           m_valid [8];
  bit           m_dirty [8];
  int unsigned  m_tag   [8];
  logic [127:0] m_data  [8];
  logic [127:0] mem_m   [int unsigned];

  always #5 clk = ~clk;

  l1_dcache_ctrl dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_stall (proc_stall),
    .proc_rdata (proc_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] backing(input int unsigned la);
    logic [31:0] b;
    if (mem_m.exists(la)) return mem_m[la];
    b = la * 32'h9E37 + 32'h1000;
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  // One processor access; the lower level answers after dr (fill) / dw (writeback) cycles.
  task automatic access(input bit rd, input bit wr, input logic [29:0] addr,
                        input logic [31:0] wd, input int dr, input int dw);
    int unsigned  idx, tg, w, fill_la, wb_la;
    bit           hit, need_wb, seen_r, seen_w, both;
    logic [127:0] wb_data, fill_data, line;
    int           exp_stall, cnt, cr, cw;
    idx       = addr[4:2];
    tg        = addr[29:5];
    w         = addr[1:0];
    hit       = m_valid[idx] && m_tag[idx] == tg;
    need_wb   = !hit && m_valid[idx] && m_dirty[idx];
    wb_la     = (m_tag[idx] << 3) | idx;
    wb_data   = m_data[idx];
    fill_la   = addr >> 2;
    fill_data = backing(fill_la);
    exp_stall = hit ? 0 : 1 + dr + (need_wb ? dw : 0);

    proc_read  = rd;
    proc_write = wr;
    proc_addr  = addr;
    proc_wdata = wd;
    #1;
    cnt = 0; cr = 0; cw = 0;
    seen_r = 0; seen_w = 0; both = 0;
    while (proc_stall && cnt < 200) begin
      if (mem_read && mem_write) both = 1;
      if (mem_write) begin
        if (!seen_w) begin
          check_eq("wb_addr", mem_addr, 128'(wb_la));
          check_eq("wb_data", mem_wdata, wb_data);
          seen_w = 1;
        end
        cw++;
        if (cw == dw) mem_ready = 1'b1;
      end else if (mem_read) begin
        if (!seen_r) begin
          check_eq("fill_addr", mem_addr, 128'(fill_la));
          seen_r = 1;
        end
        cr++;
        if (cr == dr) begin
          mem_ready = 1'b1;
          mem_rdata = fill_data;
        end
      end
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      cnt++;
      #1;
    end
    check_eq("stall_cycles", 128'(cnt), 128'(exp_stall));
    check_eq("saw_writeback", 128'(seen_w), 128'(need_wb));
    check_eq("saw_fill", 128'(seen_r), 128'(!hit));
    check_eq("rd_wr_overlap", 128'(both), 128'(0));
    check_eq("idle_req", {mem_read, mem_write}, 128'(0));
    line = hit ? m_data[idx] : fill_data;
    if (rd && !wr) check_eq("rdata", proc_rdata, 128'(line[w*32 +: 32]));

    if (need_wb) mem_m[wb_la] = wb_data;
    if (!hit) begin
      m_valid[idx] = 1;
      m_dirty[idx] = 0;
      m_tag[idx]   = tg;
      m_data[idx]  = fill_data;
    end
    if (wr) begin
      m_data[idx][w*32 +: 32] = wd;
      m_dirty[idx] = 1;
    end
    @(posedge clk);
    #1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
      m_tag[i]   = 0;
      m_data[i]  = '0;
    end
    proc_reset = 1'b1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = '0;
    proc_wdata = '0;
    mem_rdata  = '0;
    mem_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_stall", proc_stall, 0);
    check_eq("rst_mem_req", {mem_read, mem_write}, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    proc_reset = 1'b0;
    @(posedge clk);
    #1;

    // Cold read, hit, write hit, dirty eviction
    mem_m[4] = {32'h33, 32'h22, 32'h11, 32'h00};
    access(1, 0, 30'h10, 32'h0, 5, 1);
    access(1, 0, 30'h12, 32'h0, 1, 1);
    access(0, 1, 30'h11, 32'hDEADBEEF, 1, 1);
    access(1, 0, 30'h90, 32'h0, 3, 4);
    check_eq("evicted_word1", 128'(mem_m[4][63:32]), 128'(32'hDEADBEEF));

    // Clean write miss, readback, then eviction of that dirty line
    access(0, 1, 30'h148, 32'h12345678, 2, 1);
    access(1, 0, 30'h148, 32'h0, 1, 1);
    access(1, 0, 30'h1A8, 32'h0, 2, 3);
    check_eq("evicted_store", 128'(mem_m[30'h148 >> 2][31:0]), 128'(32'h12345678));

    // Read+write together on a hit acts as a store
    access(1, 1, 30'h91, 32'hCAFEF00D, 1, 1);
    access(1, 0, 30'h91, 32'h0, 1, 1);

    // Reset in the middle of a fill
    proc_read = 1'b1;
    proc_addr = 30'h200;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check_eq("midfill_req", mem_read, 1);
    proc_reset = 1'b1;
    #1;
    check_eq("midfill_rst_read", mem_read, 0);
    check_eq("midfill_rst_addr", mem_addr, 0);
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    @(posedge clk);
    #1;
    proc_reset = 1'b0;
    proc_read  = 1'b0;
    mem_ready  = 1'b1;
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    #1;
    check_eq("late_ready_read", mem_read, 0);
    check_eq("late_ready_stall", proc_stall, 0);
    access(1, 0, 30'h91, 32'h0, 2, 1);

    // Randomized traffic over a few tags so hits, clean and dirty misses all occur
    for (int n = 0; n < 300; n++) begin
      logic [29:0] a;
      int          op;
      a  = {25'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      op = $urandom_range(0, 9);
      if ($urandom_range(0, 9) == 0) begin
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
      end
      access(op < 5, op >= 5, a, $urandom, $urandom_range(1, 6), $urandom_range(1, 6));
      if (op == 9) access(1, 1, a, $urandom, 1, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
